// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between two valid/ready requesters.
//   A round-robin arbiter picks one request at a time. The operands are
//   registered and presented to the ALU for one EXEC cycle. The ALU result
//   and flags are then captured and held in HOLD until the consumer takes them.
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   req0_* / req1_*             requester handshakes (valid/ready) plus op and operands
//   alu_op/alu_rs1/alu_rs2      operands driven to the ALU from registers
//   alu_rd/alu_zero/alu_overflow  ALU outputs, sampled at the end of EXEC
//   resp_valid/resp_ready       result handshake toward the consumer
//   resp_id/resp_rd/resp_zero/resp_overflow  registered result and owner id
module alu_share_arbiter #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DWIDTH-1:0] req0_rs1,
  input  logic [DWIDTH-1:0] req0_rs2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DWIDTH-1:0] req1_rs1,
  input  logic [DWIDTH-1:0] req1_rs2,
  output logic [3:0]        alu_op,
  output logic [DWIDTH-1:0] alu_rs1,
  output logic [DWIDTH-1:0] alu_rs2,
  input  logic [DWIDTH-1:0] alu_rd,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DWIDTH-1:0] resp_rd,
  output logic              resp_zero,
  output logic              resp_overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    HOLD = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [3:0]        op_q, op_d;
  logic [DWIDTH-1:0] rs1_q, rs1_d;
  logic [DWIDTH-1:0] rs2_q, rs2_d;
  logic              owner_q, owner_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_id_q, resp_id_d;
  logic [DWIDTH-1:0] resp_rd_q, resp_rd_d;
  logic              resp_zero_q, resp_zero_d;
  logic              resp_overflow_q, resp_overflow_d;

  logic grant0_s;
  logic grant1_s;
  logic can_accept_s;
  logic accept_s;

  // Round-robin arbitration: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last_grant_q) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Acceptance window: idle, or HOLD while the result is being taken (no bubble).
  always_comb begin
    can_accept_s = 1'b0;
    case (state_q)
      IDLE:    can_accept_s = 1'b1;
      HOLD:    can_accept_s = resp_ready;
      default: can_accept_s = 1'b0;
    endcase
  end

  assign accept_s   = (grant0_s | grant1_s) & can_accept_s;
  assign req0_ready = grant0_s & can_accept_s;
  assign req1_ready = grant1_s & can_accept_s;

  // Next-state, operand capture and result capture.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    op_d            = op_q;
    rs1_d           = rs1_q;
    rs2_d           = rs2_q;
    owner_d         = owner_q;
    resp_valid_d    = resp_valid_q;
    resp_id_d       = resp_id_q;
    resp_rd_d       = resp_rd_q;
    resp_zero_d     = resp_zero_q;
    resp_overflow_d = resp_overflow_q;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // The ALU has been looking at the operand registers for a full cycle.
        state_d         = HOLD;
        resp_valid_d    = 1'b1;
        resp_id_d       = owner_q;
        resp_rd_d       = alu_rd;
        resp_zero_d     = alu_zero;
        resp_overflow_d = alu_overflow;
      end
      HOLD: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          if (accept_s) begin
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase

    if (accept_s) begin
      last_grant_d = grant1_s;
      owner_d      = grant1_s;
      if (grant1_s) begin
        op_d  = req1_op;
        rs1_d = req1_rs1;
        rs2_d = req1_rs2;
      end else begin
        op_d  = req0_op;
        rs1_d = req0_rs1;
        rs2_d = req0_rs2;
      end
    end else begin
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_grant_q    <= 1'b1;
      op_q            <= 4'b0000;
      rs1_q           <= {DWIDTH{1'b0}};
      rs2_q           <= {DWIDTH{1'b0}};
      owner_q         <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_id_q       <= 1'b0;
      resp_rd_q       <= {DWIDTH{1'b0}};
      resp_zero_q     <= 1'b0;
      resp_overflow_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      op_q            <= op_d;
      rs1_q           <= rs1_d;
      rs2_q           <= rs2_d;
      owner_q         <= owner_d;
      resp_valid_q    <= resp_valid_d;
      resp_id_q       <= resp_id_d;
      resp_rd_q       <= resp_rd_d;
      resp_zero_q     <= resp_zero_d;
      resp_overflow_q <= resp_overflow_d;
    end
  end

  // The ALU sees the operand registers at all times, so it holds its last values outside EXEC.
  assign alu_op        = op_q;
  assign alu_rs1       = rs1_q;
  assign alu_rs2       = rs2_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_rd       = resp_rd_q;
  assign resp_zero     = resp_zero_q;
  assign resp_overflow = resp_overflow_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: provides the ALU, runs directed scenarios with
// literal expectations and then a randomized phase checked every cycle against
// a transaction-level model (one op in flight, its age, and its expected result).
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
  logic [31:0] alu_rs1, alu_rs2, alu_rd, resp_rd;
  logic        alu_zero, alu_overflow;
  logic        resp_valid, resp_ready, resp_id, resp_zero, resp_overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DWIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .alu_op(alu_op), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_rd(alu_rd), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_rd(resp_rd), .resp_zero(resp_zero), .resp_overflow(resp_overflow)
  );

  // Reference ALU: returns {overflow, zero, rd}.
  function automatic logic [33:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        o;
    o = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      4'b0110: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1001: r = a << b[4:0];
      4'b1010: r = a >> b[4:0];
      4'b1100: r = ~(a | b);
      4'b1101: r = $signed(a) >>> b[4:0];
      4'b1110: r = {b[15:0], 16'h0000};
      default: r = 32'h0000_0000;
    endcase
    return {o, (r == 32'h0000_0000), r};
  endfunction

  // External ALU attached to the DUT.
  always_comb {alu_overflow, alu_zero, alu_rd} = alu_ref(alu_op, alu_rs1, alu_rs2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_init = 1'b0;
  bit          m_have = 1'b0;   // an operation is in flight
  int          m_age  = 0;      // cycles since its accept edge
  logic        m_id   = 1'b0;
  logic        m_last = 1'b1;   // who won the last accepted handshake
  logic [33:0] m_res  = '0;
  logic [3:0]  m_aop  = 4'b0000;
  logic [31:0] m_a    = 32'h0, m_b = 32'h0;

  logic e_rvalid, e_free, e_win, e_rdy0, e_rdy1, e_acc;

  // Expected handshake signals from the current model state and inputs.
  always_comb begin
    e_rvalid = m_have && (m_age >= 2);
    e_free   = !m_have || (e_rvalid && resp_ready);
    if (req0_valid && req1_valid) e_win = ~m_last;
    else                          e_win = req1_valid && !req0_valid;
    e_rdy0 = e_free && req0_valid && (e_win == 1'b0);
    e_rdy1 = e_free && req1_valid && (e_win == 1'b1);
    e_acc  = e_rdy0 || e_rdy1;
  end

  // Model advance on each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b1;
      m_have <= 1'b0;
      m_last <= 1'b1;
      m_aop  <= 4'b0000;
      m_a    <= 32'h0;
      m_b    <= 32'h0;
    end else if (e_acc) begin
      m_have <= 1'b1;
      m_age  <= 1;
      m_id   <= e_win;
      m_last <= e_win;
      m_aop  <= e_win ? req1_op  : req0_op;
      m_a    <= e_win ? req1_rs1 : req0_rs1;
      m_b    <= e_win ? req1_rs2 : req0_rs2;
      m_res  <= e_win ? alu_ref(req1_op, req1_rs1, req1_rs2) : alu_ref(req0_op, req0_rs1, req0_rs2);
    end else if (e_rvalid && resp_ready) begin
      m_have <= 1'b0;
    end else if (m_have) begin
      m_age <= m_age + 1;
    end
  end

  // Compare process: every cycle on the falling edge.
  always @(negedge clk) begin
    if (m_init) begin
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, e_rdy0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, e_rdy1});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_rvalid});
      chk("alu_op", {28'd0, alu_op}, {28'd0, m_aop});
      chk("alu_rs1", alu_rs1, m_a);
      chk("alu_rs2", alu_rs2, m_b);
      if (e_rvalid) begin
        chk("resp_id", {31'd0, resp_id}, {31'd0, m_id});
        chk("resp_rd", resp_rd, m_res[31:0]);
        chk("resp_zero", {31'd0, resp_zero}, {31'd0, m_res[32]});
        chk("resp_overflow", {31'd0, resp_overflow}, {31'd0, m_res[33]});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_op = 4'b0000; req0_rs1 = 32'h0; req0_rs2 = 32'h0;
    req1_valid = 1'b0; req1_op = 4'b0000; req1_rs1 = 32'h0; req1_rs2 = 32'h0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] rnd_op();
    logic [3:0] ops [11];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1001,
            4'b1010, 4'b1100, 4'b1101, 4'b1110, 4'b0011};
    return ops[$urandom_range(0, 10)];
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  int g_who [8];
  int g_cyc [8];
  int ng;
  bit a0, a1;

  initial begin
    rst = 1'b1;
    resp_ready = 1'b1;
    idle_inputs();
    do_reset(3);

    // Reset state
    @(negedge clk);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rd", resp_rd, 32'h0);
    chk("rst_resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    tick();

    // 1: lone ADD with signed overflow
    req0_valid = 1'b1; req0_op = 4'b0010; req0_rs1 = 32'h7FFF_FFFF; req0_rs2 = 32'h0000_0001;
    @(negedge clk);
    chk("t1_ready_T", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_valid_T1", {31'd0, resp_valid}, 32'd0);
    chk("t1_alu_rs1", alu_rs1, 32'h7FFF_FFFF);
    tick();
    @(negedge clk);
    chk("t1_valid_T2", {31'd0, resp_valid}, 32'd1);
    chk("t1_rd", resp_rd, 32'h8000_0000);
    chk("t1_ovf", {31'd0, resp_overflow}, 32'd1);
    chk("t1_zero", {31'd0, resp_zero}, 32'd0);
    chk("t1_id", {31'd0, resp_id}, 32'd0);
    tick();

    // 2: both valid every cycle -> alternating grants
    do_reset(2);
    req0_valid = 1'b1; req0_op = 4'b0110; req0_rs1 = 32'd5;   req0_rs2 = 32'd5;
    req1_valid = 1'b1; req1_op = 4'b0001; req1_rs1 = 32'hF0;  req1_rs2 = 32'h0F;
    ng = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ng < 8 && req0_ready) begin g_who[ng] = 0; g_cyc[ng] = c; ng++; end
      if (ng < 8 && req1_ready) begin g_who[ng] = 1; g_cyc[ng] = c; ng++; end
      if (resp_valid) begin
        if (resp_id == 1'b0) begin
          chk("t2_rd0", resp_rd, 32'h0);
          chk("t2_zero0", {31'd0, resp_zero}, 32'd1);
        end else begin
          chk("t2_rd1", resp_rd, 32'hFF);
          chk("t2_zero1", {31'd0, resp_zero}, 32'd0);
        end
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2_ngrants", 32'(ng), 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) begin
        chk("t2_grant", 32'(g_who[i]), 32'(i % 2));
        chk("t2_spacing", 32'(g_cyc[i]), 32'(2 * i));
      end
    end
    for (int i = 0; i < 3; i++) tick();

    // 3: SLT held with resp_ready low; req0 waits, then accepted on the release edge
    resp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 4'b0111; req1_rs1 = 32'hFFFF_FFFF; req1_rs2 = 32'd1;
    @(negedge clk);
    chk("t3_req1_ready", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0000; req0_rs1 = 32'hFF; req0_rs2 = 32'h0F;
    @(negedge clk);
    chk("t3_exec_req0_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("t3_hold_rd", resp_rd, 32'd1);
      chk("t3_hold_id", {31'd0, resp_id}, 32'd1);
      chk("t3_hold_req0_ready", {31'd0, req0_ready}, 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t3_and_rd", resp_rd, 32'h0F);
    chk("t3_and_id", {31'd0, resp_id}, 32'd0);
    tick();

    // 4: reset during EXEC discards the op and restores the tie-break to req0
    req0_valid = 1'b1; req0_op = 4'b0110; req0_rs1 = 32'h8000_0000; req0_rs2 = 32'd1;
    tick();
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("t4_exec_alu_op", {28'd0, alu_op}, 32'h6);
    tick();
    rst = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_rs1 = 32'd3; req0_rs2 = 32'd4;
    req1_valid = 1'b1; req1_op = 4'b0001; req1_rs1 = 32'd1; req1_rs2 = 32'd2;
    @(negedge clk);
    chk("t4_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("t4_tie_req0", {31'd0, req0_ready}, 32'd1);
    chk("t4_tie_req1", {31'd0, req1_ready}, 32'd0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t4_rd", resp_rd, 32'd7);
    tick();

    // 5: back-to-back SLL then SRA from req0, no bubble
    req0_valid = 1'b1; req0_op = 4'b1001; req0_rs1 = 32'd1; req0_rs2 = 32'd31;
    @(negedge clk);
    chk("t5_ready0", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_op = 4'b1101; req0_rs1 = 32'h8000_0000; req0_rs2 = 32'd4;
    @(negedge clk);
    chk("t5_exec_ready", {31'd0, req0_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_sll_rd", resp_rd, 32'h8000_0000);
    chk("t5_ready1", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t5_exec_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("t5_sra_rd", resp_rd, 32'hF800_0000);
    tick();

    // Randomized phase
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      tick();
      rst = ($urandom_range(0, 199) == 0);
      if (!req0_valid || a0) begin
        if ($urandom_range(0, 2) != 0) begin
          req0_valid = 1'b1; req0_op = rnd_op(); req0_rs1 = rnd_opnd(); req0_rs2 = rnd_opnd();
        end else begin
          req0_valid = 1'b0;
        end
      end
      if (!req1_valid || a1) begin
        if ($urandom_range(0, 2) != 0) begin
          req1_valid = 1'b1; req1_op = rnd_op(); req1_rs1 = rnd_opnd(); req1_rs2 = rnd_opnd();
        end else begin
          req1_valid = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    idle_inputs();
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
